// File: rtl/vf_ref_gen_pkg.sv
// Shared types and constants for the V/f three-phase reference generator.
// Holds the sequencer state encoding and the quarter-wave sine table builder.
package vf_ref_pkg;

  localparam int unsigned PHASE_W_DEF = 32;
  localparam int unsigned LUT_AW_DEF  = 8;
  localparam int unsigned OUT_W_DEF   = 16;
  localparam int unsigned AMP_W       = 16;
  localparam int unsigned AMP_FRAC_W  = 16;

  // -120 deg and +120 deg as fractions of a full turn
  localparam logic [31:0] PH_OFF_V = 32'hAAAA_AAAB;
  localparam logic [31:0] PH_OFF_W = 32'h5555_5555;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACC,
    S_U_ADDR,
    S_U_ROM,
    S_U_MUL,
    S_V_ADDR,
    S_V_ROM,
    S_V_MUL,
    S_W_ADDR,
    S_W_ROM,
    S_W_MUL,
    S_OUT
  } state_e;

  // round((2^dw-1) * sin(pi/2 * (k+0.5) / 2^aw)), evaluated with a Q60
  // Taylor series so the table is built at elaboration without real math.
  function automatic logic [31:0] qsin_entry(input int unsigned k,
                                             input int unsigned aw,
                                             input int unsigned dw);
    logic [127:0] pi_q60;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc;
    logic [127:0] full;
    logic [127:0] scaled;
    pi_q60 = 128'h3243_F6A8_885A_308D;
    x      = (pi_q60 * 128'(2 * k + 1)) >> (aw + 2);
    x2     = (x * x) >> 60;
    term   = x;
    acc    = x;
    for (int unsigned n = 1; n <= 12; n++) begin
      term = (term * x2) >> 60;
      term = term / 128'((2 * n) * (2 * n + 1));
      if (n[0]) acc = acc - term;
      else      acc = acc + term;
    end
    full   = (128'(1) << dw) - 128'(1);
    scaled = (acc * full + (128'(1) << 59)) >> 60;
    return scaled[31:0];
  endfunction

endpackage

// File: rtl/vf_ref_gen_if.sv
// Control/reference bundle between the carrier logic and vf_ref_gen.
interface vf_ref_gen_if
  import vf_ref_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF
);
  logic                       EN;
  logic                       UPDATE_STB;
  logic [PHASE_W-1:0]         FREQ_WORD;
  logic [AMP_W-1:0]           AMPLITUDE;
  logic signed [OUT_W-1:0]    VU_REF;
  logic signed [OUT_W-1:0]    VV_REF;
  logic signed [OUT_W-1:0]    VW_REF;
  logic                       REF_VALID;
  logic                       BUSY;
  logic [PHASE_W-1:0]         PHASE;
  logic                       OVERRUN;

  modport master (
    output EN, UPDATE_STB, FREQ_WORD, AMPLITUDE,
    input  VU_REF, VV_REF, VW_REF, REF_VALID, BUSY, PHASE, OVERRUN
  );

  modport slave (
    input  EN, UPDATE_STB, FREQ_WORD, AMPLITUDE,
    output VU_REF, VV_REF, VW_REF, REF_VALID, BUSY, PHASE, OVERRUN
  );
endinterface

// File: rtl/vf_ref_gen_qrom.sv
// Registered quarter-wave sine ROM, one read port, contents built at elaboration.
module sine_qrom
  import vf_ref_pkg::*;
#(
  parameter int unsigned AW = LUT_AW_DEF,
  parameter int unsigned DW = OUT_W_DEF - 1
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  output logic [DW-1:0] data_o
);
  localparam int unsigned DEPTH = 1 << AW;

  typedef logic [DW-1:0] word_t;
  typedef word_t [DEPTH-1:0] tbl_t;

  function automatic tbl_t build_tbl();
    tbl_t t;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      t[k] = DW'(qsin_entry(k, AW, DW));
    end
    return t;
  endfunction

  localparam tbl_t TBL = build_tbl();

  always_ff @(posedge clk_i) begin
    data_o <= TBL[addr_i];
  end
endmodule

// File: rtl/vf_ref_gen.sv
// Three-phase V/f sine reference generator; U, V and W are computed in turn
// on one shared ROM read port and one 15x16 multiplier, then published together.
module vf_ref_gen
  import vf_ref_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned LUT_AW  = LUT_AW_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  vf_ref_gen_if.slave bus
);
  localparam int unsigned MAG_W  = OUT_W - 1;
  localparam int unsigned PROD_W = MAG_W + AMP_W;

  state_e state_q, state_d;

  logic [PHASE_W-1:0]      phase_q, freq_q;
  logic [AMP_W-1:0]        amp_q;
  logic                    en_q, busy_q, ref_valid_q, overrun_q;
  logic [1:0]              quad_q;
  logic [LUT_AW-1:0]       rom_addr_q;
  logic signed [OUT_W-1:0] hold_u_q, hold_v_q, hold_w_q;
  logic signed [OUT_W-1:0] vu_q, vv_q, vw_q;

  logic                    accept;
  logic [PHASE_W-1:0]      ch_off, ch_phase;
  logic [1:0]              ch_quad;
  logic [LUT_AW-1:0]       ch_idx, ch_addr;
  logic [MAG_W-1:0]        rom_data, mag;
  logic [PROD_W-1:0]       prod;
  logic signed [OUT_W-1:0] smag;

  // BUSY covers the REF_VALID cycle, so a strobe coincident with it is refused
  assign accept = bus.UPDATE_STB && !busy_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = S_ACC;
      S_ACC:    state_d = S_U_ADDR;
      S_U_ADDR: state_d = S_U_ROM;
      S_U_ROM:  state_d = S_U_MUL;
      S_U_MUL:  state_d = S_V_ADDR;
      S_V_ADDR: state_d = S_V_ROM;
      S_V_ROM:  state_d = S_V_MUL;
      S_V_MUL:  state_d = S_W_ADDR;
      S_W_ADDR: state_d = S_W_ROM;
      S_W_ROM:  state_d = S_W_MUL;
      S_W_MUL:  state_d = S_OUT;
      S_OUT:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_off = '0;
    case (state_q)
      S_V_ADDR: ch_off = PH_OFF_V[PHASE_W-1:0];
      S_W_ADDR: ch_off = PH_OFF_W[PHASE_W-1:0];
      default:  ch_off = '0;
    endcase
    ch_phase = phase_q + ch_off;
    ch_quad  = ch_phase[PHASE_W-1 -: 2];
    ch_idx   = ch_phase[PHASE_W-3 -: LUT_AW];
    // odd quadrants run the quarter wave backwards
    ch_addr  = ch_quad[0] ? ~ch_idx : ch_idx;

    prod = PROD_W'(rom_data) * PROD_W'(amp_q);
    mag  = prod[AMP_FRAC_W +: MAG_W];
    smag = quad_q[1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

  sine_qrom #(
    .AW (LUT_AW),
    .DW (MAG_W)
  ) u_qrom (
    .clk_i  (CLK),
    .addr_i (rom_addr_q),
    .data_o (rom_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      freq_q      <= '0;
      amp_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      ref_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      quad_q      <= '0;
      rom_addr_q  <= '0;
      hold_u_q    <= '0;
      hold_v_q    <= '0;
      hold_w_q    <= '0;
      vu_q        <= '0;
      vv_q        <= '0;
      vw_q        <= '0;
    end else begin
      state_q     <= state_d;
      ref_valid_q <= (state_q == S_OUT);

      if (accept) begin
        en_q   <= bus.EN;
        freq_q <= bus.FREQ_WORD;
        amp_q  <= bus.AMPLITUDE;
        busy_q <= 1'b1;
      end else if (ref_valid_q) begin
        busy_q <= 1'b0;
      end

      if (bus.UPDATE_STB && busy_q) overrun_q <= 1'b1;

      if (state_q == S_ACC && en_q) phase_q <= phase_q + freq_q;

      if (state_q == S_U_ADDR || state_q == S_V_ADDR || state_q == S_W_ADDR) begin
        rom_addr_q <= ch_addr;
        quad_q     <= ch_quad;
      end

      if (state_q == S_U_MUL) hold_u_q <= smag;
      if (state_q == S_V_MUL) hold_v_q <= smag;
      if (state_q == S_W_MUL) hold_w_q <= smag;

      if (state_q == S_OUT) begin
        vu_q <= en_q ? hold_u_q : '0;
        vv_q <= en_q ? hold_v_q : '0;
        vw_q <= en_q ? hold_w_q : '0;
      end
    end
  end

  assign bus.VU_REF    = vu_q;
  assign bus.VV_REF    = vv_q;
  assign bus.VW_REF    = vw_q;
  assign bus.REF_VALID = ref_valid_q;
  assign bus.BUSY      = busy_q;
  assign bus.PHASE     = phase_q;
  assign bus.OVERRUN   = overrun_q;
endmodule

// File: tb/tb_vf_ref_gen.sv
// Self-checking bench for vf_ref_gen: vector table, random sweep against a
// quadrant/ROM model, plus overrun and reset corner sequences.
module tb_vf_ref_gen;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vf_ref_gen_if bus ();

  vf_ref_gen dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          rom_m[256];
  logic [31:0] m_phase;

  typedef struct {
    logic        en;
    logic [31:0] freq;
    logic [15:0] amp;
    logic [31:0] exp_phase;
    bit          has_u;
    int          exp_u;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Sine sample from the spec's quadrant rules and a real-valued quarter table
  function automatic int model_ref(input logic [31:0] ph, input logic [15:0] amp);
    longint unsigned p;
    longint          mag;
    int              q, i, a;
    p   = 64'(ph);
    q   = int'(p / (64'd1 << 30));
    i   = int'((p / (64'd1 << 22)) % 256);
    a   = (q % 2 == 1) ? 255 - i : i;
    mag = (longint'(rom_m[a]) * longint'(amp)) / 65536;
    return (q >= 2) ? -int'(mag) : int'(mag);
  endfunction

  task automatic pulse_stb(input logic en, input logic [31:0] f, input logic [15:0] amp);
    @(negedge clk);
    bus.EN         = en;
    bus.FREQ_WORD  = f;
    bus.AMPLITUDE  = amp;
    bus.UPDATE_STB = 1'b1;
    @(posedge clk);
    #1;
    bus.UPDATE_STB = 1'b0;
  endtask

  task automatic run_update(input logic en, input logic [31:0] f, input logic [15:0] amp,
                            output int u, output int v, output int w);
    int cyc;
    bit seen;
    int eu, ev, ew;
    pulse_stb(en, f, amp);
    check("busy_after_accept", longint'(bus.BUSY), 1);
    if (en) m_phase = m_phase + f;
    eu = en ? model_ref(m_phase, amp) : 0;
    ev = en ? model_ref(m_phase + 32'hAAAA_AAAB, amp) : 0;
    ew = en ? model_ref(m_phase + 32'h5555_5555, amp) : 0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check("phase_after_acc", longint'(bus.PHASE), longint'(m_phase));
      if (bus.REF_VALID) seen = 1'b1;
    end
    check("ref_valid_latency", seen ? cyc : -1, 11);
    u = int'($signed(bus.VU_REF));
    v = int'($signed(bus.VV_REF));
    w = int'($signed(bus.VW_REF));
    check("vu_ref", u, eu);
    check("vv_ref", v, ev);
    check("vw_ref", w, ew);
    check("ref_not_min", longint'(u == -32768 || v == -32768 || w == -32768), 0);
    @(posedge clk);
    #1;
    check("ref_valid_one_cycle", longint'(bus.REF_VALID), 0);
    check("busy_release", longint'(bus.BUSY), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vu"}, longint'(bus.VU_REF), 0);
    check({tag, "_vv"}, longint'(bus.VV_REF), 0);
    check({tag, "_vw"}, longint'(bus.VW_REF), 0);
    check({tag, "_phase"}, longint'(bus.PHASE), 0);
    check({tag, "_valid"}, longint'(bus.REF_VALID), 0);
    check({tag, "_busy"}, longint'(bus.BUSY), 0);
    check({tag, "_overrun"}, longint'(bus.OVERRUN), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int u, v, w, u2, v2, w2, cnt;
    bit seen;

    for (int k = 0; k < 256; k++) begin
      rom_m[k] = int'($floor(32767.0 * $sin(3.14159265358979323846 / 2.0 * (real'(k) + 0.5) / 256.0) + 0.5));
    end

    vecs[0] = '{1'b1, 32'h4000_0000, 16'hFFFF, 32'h4000_0000, 1'b1, 32766};
    vecs[1] = '{1'b1, 32'h4000_0000, 16'hFFFF, 32'h8000_0000, 1'b1, -100};
    vecs[2] = '{1'b0, 32'h1234_5678, 16'hFFFF, 32'h8000_0000, 1'b1, 0};
    vecs[3] = '{1'b1, 32'h0000_0000, 16'h8000, 32'h8000_0000, 1'b1, -50};
    vecs[4] = '{1'b1, 32'h2000_0000, 16'h0000, 32'hA000_0000, 1'b1, 0};
    vecs[5] = '{1'b1, 32'hC000_0000, 16'hFFFF, 32'h6000_0000, 1'b0, 0};
    vecs[6] = '{1'b1, 32'hE000_0000, 16'h8000, 32'h4000_0000, 1'b1, 16383};

    bus.EN         = 1'b0;
    bus.UPDATE_STB = 1'b0;
    bus.FREQ_WORD  = '0;
    bus.AMPLITUDE  = '0;
    rst            = 1'b1;
    m_phase        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // table vectors
    for (int t = 0; t < 7; t++) begin
      run_update(vecs[t].en, vecs[t].freq, vecs[t].amp, u, v, w);
      check("vec_phase", longint'(bus.PHASE), longint'(vecs[t].exp_phase));
      if (vecs[t].has_u) check("vec_vu", u, vecs[t].exp_u);
      if (t == 0) begin
        check("quarter_vv_near", longint'(v >= -16424 && v <= -16344), 1);
        check("quarter_vw_near", longint'(w >= -16424 && w <= -16344), 1);
      end
    end

    // constant output with zero frequency word
    run_update(1'b1, 32'h0, 16'hFFFF, u, v, w);
    run_update(1'b1, 32'h0, 16'hFFFF, u2, v2, w2);
    check("const_vu", u2, u);
    check("const_vv", v2, v);
    check("const_vw", w2, w);

    // wrap sweep
    for (int s = 0; s < 300; s++) begin
      run_update(1'b1, 32'h0100_0000, 16'hFFFF, u, v, w);
    end

    // random updates
    for (int s = 0; s < 40; s++) begin
      run_update(($urandom_range(0, 7) != 0), $urandom,
                 ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535)),
                 u, v, w);
    end

    // overrun: second strobe five cycles after the first
    pulse_stb(1'b1, 32'h0100_0000, 16'hFFFF);
    m_phase = m_phase + 32'h0100_0000;
    repeat (4) @(negedge clk);
    bus.FREQ_WORD  = 32'h7000_0000;
    bus.AMPLITUDE  = 16'h0000;
    bus.UPDATE_STB = 1'b1;
    @(posedge clk);
    #1;
    bus.UPDATE_STB = 1'b0;
    check("overrun_set", longint'(bus.OVERRUN), 1);
    cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus.REF_VALID) begin
        cnt++;
        check("overrun_vu", longint'($signed(bus.VU_REF)), model_ref(m_phase, 16'hFFFF));
        check("overrun_vv", longint'($signed(bus.VV_REF)), model_ref(m_phase + 32'hAAAA_AAAB, 16'hFFFF));
      end
    end
    check("overrun_single_valid", cnt, 1);
    check("overrun_phase_once", longint'(bus.PHASE), longint'(m_phase));
    run_update(1'b1, 32'h0020_0000, 16'hFFFF, u, v, w);
    check("overrun_sticky", longint'(bus.OVERRUN), 1);

    // reset mid-computation
    pulse_stb(1'b1, 32'h1234_5678, 16'hFFFF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst     = 1'b0;
    m_phase = '0;
    cnt     = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.REF_VALID) cnt++;
    end
    check("midreset_no_valid", cnt, 0);
    run_update(1'b1, 32'h0800_0000, 16'hC000, u, v, w);
    check("midreset_no_overrun", longint'(bus.OVERRUN), 0);

    // strobe coincident with REF_VALID is an overrun and is not accepted
    pulse_stb(1'b1, 32'h0300_0000, 16'hFFFF);
    m_phase = m_phase + 32'h0300_0000;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (bus.REF_VALID) seen = 1'b1;
    end
    check("coincident_valid_seen", longint'(seen), 1);
    bus.UPDATE_STB = 1'b1;
    @(posedge clk);
    #1;
    bus.UPDATE_STB = 1'b0;
    check("coincident_overrun", longint'(bus.OVERRUN), 1);
    check("coincident_busy", longint'(bus.BUSY), 0);
    cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.REF_VALID || bus.BUSY) cnt++;
    end
    check("coincident_ignored", cnt, 0);
    check("coincident_phase", longint'(bus.PHASE), longint'(m_phase));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
